// File: rtl/seg7_result_display.sv
// seg7_result_display
// Converts a loaded result byte to three BCD digits with a sequential
// double-dabble engine, then time-multiplexes a 4-digit active-low
// seven-segment display: decimal hundreds/tens/units on digits 2..0 and an
// auxiliary hex nibble on digit 3.
//
// Handshake: load is a single-cycle strobe sampled on the rising edge.
// It is accepted only while busy is low (FSM in IDLE). Strobes that arrive
// while busy is high are dropped, not queued. done is a one-cycle pulse that
// coincides with the new digits becoming visible to the display path.
module seg7_result_display #(
  parameter int REFRESH_BITS = 18,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] result,
  input  logic       load,
  input  logic [3:0] aux,
  input  logic       aux_en,
  output logic       busy,
  output logic       done,
  output logic [6:0] LED_out,
  output logic [3:0] Anode_Activate,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_shreg;
  logic [11:0]             r_bcd;
  logic [2:0]              r_cnt;
  logic [3:0]              r_h;
  logic [3:0]              r_t;
  logic [3:0]              r_u;
  logic                    r_done;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [6:0]              r_led;
  logic [3:0]              r_anode;

  logic [11:0] w_adj;
  logic [19:0] w_shifted;
  logic [1:0]  w_sel;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [3:0]  w_anode;

  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign LED_out        = r_led;
  assign Anode_Activate = r_anode;
  assign o_dbg_state    = r_state;

  // Active-low segment pattern {a,b,c,d,e,f,g} for one hex digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0:    seg_code = 7'b0000001;
      4'h1:    seg_code = 7'b1001111;
      4'h2:    seg_code = 7'b0010010;
      4'h3:    seg_code = 7'b0000110;
      4'h4:    seg_code = 7'b1001100;
      4'h5:    seg_code = 7'b0100100;
      4'h6:    seg_code = 7'b0100000;
      4'h7:    seg_code = 7'b0001111;
      4'h8:    seg_code = 7'b0000000;
      4'h9:    seg_code = 7'b0000100;
      4'hA:    seg_code = 7'b0001000;
      4'hB:    seg_code = 7'b1100000;
      4'hC:    seg_code = 7'b0110001;
      4'hD:    seg_code = 7'b1000010;
      4'hE:    seg_code = 7'b0110000;
      default: seg_code = 7'b0111000;
    endcase
  endfunction

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift the
  // concatenated {bcd, shreg} left by one bit.
  always_comb begin
    w_adj[3:0]   = (r_bcd[3:0]   >= 4'd5) ? r_bcd[3:0]   + 4'd3 : r_bcd[3:0];
    w_adj[7:4]   = (r_bcd[7:4]   >= 4'd5) ? r_bcd[7:4]   + 4'd3 : r_bcd[7:4];
    w_adj[11:8]  = (r_bcd[11:8]  >= 4'd5) ? r_bcd[11:8]  + 4'd3 : r_bcd[11:8];
    w_shifted    = {w_adj, r_shreg} << 1;
  end

  // Converter FSM: capture in IDLE, eight shift cycles, latch digits in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shreg <= 8'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      r_h     <= 4'd0;
      r_t     <= 4'd0;
      r_u     <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shreg <= result;
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd   <= w_shifted[19:8];
          r_shreg <= w_shifted[7:0];
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_h     <= r_bcd[11:8];
          r_t     <= r_bcd[7:4];
          r_u     <= r_bcd[3:0];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

  // Pick the digit, anode and blanking for the slot selected by the counter.
  always_comb begin
    w_digit = r_u;
    w_blank = 1'b0;
    w_anode = 4'b1110;
    case (w_sel)
      2'd0: begin
        w_digit = r_u;
        w_anode = 4'b1110;
      end
      2'd1: begin
        w_digit = r_t;
        w_blank = LZB && (r_h == 4'd0) && (r_t == 4'd0);
        w_anode = 4'b1101;
      end
      2'd2: begin
        w_digit = r_h;
        w_blank = LZB && (r_h == 4'd0);
        w_anode = 4'b1011;
      end
      default: begin
        w_digit = aux;
        w_blank = !aux_en;
        w_anode = 4'b0111;
      end
    endcase
  end

  // Free-running refresh counter plus registered segment/anode outputs,
  // so both change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_led     <= 7'b1111111;
      r_anode   <= 4'b1111;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
      r_led     <= w_blank ? 7'b1111111 : seg_code(w_digit);
      r_anode   <= w_anode;
    end
  end

endmodule

// File: tb/tb_seg7_result_display.sv
// Directed testbench for seg7_result_display with a 4-cycle digit period.
// A second instance with leading-zero blanking disabled shares all inputs.
module tb_seg7_result_display;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] result;
  logic       load;
  logic [3:0] aux;
  logic       aux_en;
  logic       busy, done;
  logic [6:0] LED_out;
  logic [3:0] Anode_Activate;
  logic [1:0] dbg_state;
  logic       busy_n, done_n;
  logic [6:0] led_n;
  logic [3:0] anode_n;
  logic [1:0] dbg_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  seg7_result_display #(.REFRESH_BITS(4), .LZB(1'b1)) u_dut (
    .clk(clk), .reset(reset), .result(result), .load(load), .aux(aux),
    .aux_en(aux_en), .busy(busy), .done(done), .LED_out(LED_out),
    .Anode_Activate(Anode_Activate), .o_dbg_state(dbg_state)
  );

  seg7_result_display #(.REFRESH_BITS(4), .LZB(1'b0)) u_dut_nolzb (
    .clk(clk), .reset(reset), .result(result), .load(load), .aux(aux),
    .aux_en(aux_en), .busy(busy_n), .done(done_n), .LED_out(led_n),
    .Anode_Activate(anode_n), .o_dbg_state(dbg_n)
  );

  // Scoreboard check
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    result = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Wait for a fresh transition onto the given anode pattern.
  task automatic wait_anode(input logic [3:0] a);
    int n;
    n = 0;
    while (Anode_Activate === a && n < 40) begin @(negedge clk); n++; end
    while (Anode_Activate !== a && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check_val("anode_wait", 16'(Anode_Activate), 16'(a));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check_val("done_seen", 16'(done), 16'd1);
  endtask

  task automatic check_digits(input logic [6:0] eu, input logic [6:0] et, input logic [6:0] eh);
    wait_anode(4'b1110);
    check_val("seg_units", 16'(LED_out), 16'(eu));
    wait_anode(4'b1101);
    check_val("seg_tens", 16'(LED_out), 16'(et));
    wait_anode(4'b1011);
    check_val("seg_hundreds", 16'(LED_out), 16'(eh));
  endtask

  initial begin
    logic saw_done;
    reset  = 1'b1;
    result = 8'd0;
    load   = 1'b0;
    aux    = 4'h0;
    aux_en = 1'b0;

    // 1. Reset state and blank-after-reset display
    repeat (2) @(negedge clk);
    check_val("rst_led", 16'(LED_out), 16'(BLANK));
    check_val("rst_anode", 16'(Anode_Activate), 16'hF);
    check_val("rst_busy", 16'(busy), 16'd0);
    check_val("rst_done", 16'(done), 16'd0);
    check_val("rst_state", 16'(dbg_state), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_anode", 16'(Anode_Activate), 16'hE);
    check_val("post_rst_led", 16'(LED_out), 16'(SEG_0));
    check_digits(SEG_0, BLANK, BLANK);

    // 2. 173 -> H=1 T=7 U=3, busy for 9 cycles, done at k+9
    do_load(8'd173);
    for (int i = 0; i < 9; i++) begin
      check_val("busy_window", 16'(busy), 16'd1);
      check_val("done_early", 16'(done), 16'd0);
      @(negedge clk);
    end
    check_val("busy_end", 16'(busy), 16'd0);
    check_val("done_k9", 16'(done), 16'd1);
    @(negedge clk);
    check_val("done_one_cycle", 16'(done), 16'd0);
    check_digits(SEG_3, SEG_7, SEG_1);

    // 3. 255 with a second load at k+3 that must be ignored
    do_load(8'd255);
    repeat (2) @(negedge clk);
    result = 8'd7;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    check_val("busy_during_ignored", 16'(busy), 16'd1);
    wait_done();
    @(negedge clk);
    check_val("no_queued_load", 16'(busy), 16'd0);
    check_digits(SEG_5, SEG_5, SEG_2);
    do_load(8'd7);
    wait_done();
    check_digits(SEG_7, BLANK, BLANK);

    // 4. Load accepted at k+10; value 5 with and without blanking
    do_load(8'd128);
    wait_done();
    result = 8'd5;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    check_val("load_k10", 16'(busy), 16'd1);
    wait_done();
    check_digits(SEG_5, BLANK, BLANK);
    wait_anode(4'b1101);
    check_val("nolzb_tens", 16'(led_n), 16'(SEG_0));
    wait_anode(4'b1011);
    check_val("nolzb_hundreds", 16'(led_n), 16'(SEG_0));

    // 5. Aux digit shown and blanked
    aux    = 4'hB;
    aux_en = 1'b1;
    wait_anode(4'b0111);
    check_val("aux_on", 16'(LED_out), 16'(SEG_B));
    aux_en = 1'b0;
    wait_anode(4'b0111);
    check_val("aux_off", 16'(LED_out), 16'(BLANK));

    // 6. Reset at k+4 aborts the conversion and clears the digits
    do_load(8'd200);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_busy", 16'(busy), 16'd0);
    check_val("abort_anode", 16'(Anode_Activate), 16'hF);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check_val("abort_no_done", 16'(saw_done), 16'd0);
    check_digits(SEG_0, BLANK, BLANK);
    wait_anode(4'b1011);
    check_val("abort_nolzb_h", 16'(led_n), 16'(SEG_0));

    // Counter wrap 15 -> 0 returns the anode to the units slot
    wait_anode(4'b0111);
    repeat (3) @(negedge clk);
    check_val("wrap_hold", 16'(Anode_Activate), 16'h7);
    @(negedge clk);
    check_val("wrap_units", 16'(Anode_Activate), 16'hE);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
